// File: rtl/latch_write_sequencer.sv
// -----------------------------------------------------------------------------
// latch_write_sequencer
//
// Upstream driver for a transparent latch bank. Each accepted word is presented
// on latch_data and then run through a timed write window:
//   SETUP : data stable, enable low   (SETUP_CYC cycles)
//   OPEN  : data stable, enable high  (OPEN_CYC cycles)
//   HOLD  : data stable, enable low   (HOLD_CYC cycles)
// Both latch outputs come straight from flops, so the latch sees a glitch-free
// enable and data that never moves around an enable edge.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE (and never during reset). Upstream must keep
// in_data stable until the transfer happens; anything presented while busy is
// ignored.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst_n        in   synchronous reset, active low
//   in_valid     in   upstream word valid
//   in_ready     out  sequencer can accept a word (combinational)
//   in_data      in   upstream word, WIDTH bits
//   latch_data   out  registered word driving the latch data input
//   latch_enable out  registered latch enable
//   busy         out  high in SETUP, OPEN or HOLD
//   done         out  one-cycle pulse in the first IDLE cycle after HOLD
//   dbg_state    out  current FSM state encoding (IDLE=0 SETUP=1 OPEN=2 HOLD=3)
// -----------------------------------------------------------------------------
module latch_write_sequencer #(
    parameter int WIDTH     = 1,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] latch_data,
    output logic             latch_enable,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Phase lengths of zero would collapse the window and break the
    // data-stable-around-enable guarantee, so refuse to build.
    if (SETUP_CYC < 1 || OPEN_CYC < 1 || HOLD_CYC < 1) begin : g_bad_params
        $error("latch_write_sequencer: SETUP_CYC, OPEN_CYC and HOLD_CYC must all be >= 1");
    end

    localparam int MAX_A   = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LEN = CW'(SETUP_CYC);
    localparam logic [CW-1:0] OPEN_LEN  = CW'(OPEN_CYC);
    localparam logic [CW-1:0] HOLD_LEN  = CW'(HOLD_CYC);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [WIDTH-1:0] data_nx;
    logic            en_nx;
    logic            done_nx;

    // in_ready/busy are forced low while reset is asserted so upstream never
    // sees a transfer opportunity during reset.
    assign in_ready  = rst_n && (state == IDLE);
    assign busy      = rst_n && (state != IDLE);
    assign dbg_state = state;

    // The counter holds the number of cycles already spent in the current
    // phase (starting at 1 on entry), so it never exceeds the phase length.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        data_nx  = latch_data;
        en_nx    = latch_enable;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                en_nx = 1'b0;
                if (in_valid) begin
                    data_nx  = in_data;
                    cnt_nx   = CNT_ONE;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LEN) begin
                    en_nx    = 1'b1;
                    cnt_nx   = CNT_ONE;
                    state_nx = OPEN;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            OPEN: begin
                if (cnt == OPEN_LEN) begin
                    en_nx    = 1'b0;
                    cnt_nx   = CNT_ONE;
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LEN) begin
                    cnt_nx   = '0;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                en_nx    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            latch_data   <= '0;
            latch_enable <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            latch_data   <= data_nx;
            latch_enable <= en_nx;
            done         <= done_nx;
        end
    end

endmodule

// File: tb/tb_latch_write_sequencer.sv
// -----------------------------------------------------------------------------
// tb_latch_write_sequencer
//
// Directed bench for latch_write_sequencer. dut_a uses S=2 O=3 H=1, dut_b uses
// S=O=H=1. Inputs are driven 1 time unit after the rising edge and outputs are
// checked at that same point; the enable-stability monitors sample on the
// falling edge. Cycle k below means "just after accept edge t0 + k".
// -----------------------------------------------------------------------------
module tb_latch_write_sequencer;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: S=2 O=3 H=1 ----------------
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] latch_data;
    logic       latch_enable;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    latch_write_sequencer #(
        .WIDTH(8), .SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(1)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .latch_data   (latch_data),
        .latch_enable (latch_enable),
        .busy         (busy),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    // ---------------- DUT B: S=O=H=1 ----------------
    logic       in_valid_b;
    logic       in_ready_b;
    logic [7:0] in_data_b;
    logic [7:0] latch_data_b;
    logic       latch_enable_b;
    logic       busy_b;
    logic       done_b;
    logic [1:0] dbg_state_b;

    latch_write_sequencer #(
        .WIDTH(8), .SETUP_CYC(1), .OPEN_CYC(1), .HOLD_CYC(1)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid_b),
        .in_ready     (in_ready_b),
        .in_data      (in_data_b),
        .latch_data   (latch_data_b),
        .latch_enable (latch_enable_b),
        .busy         (busy_b),
        .done         (done_b),
        .dbg_state    (dbg_state_b)
    );

    // ---------------- scoreboard ----------------
    int n_cmp;
    int n_bad;
    logic [7:0] exp_word;    // word dut_a must hold whenever enable is high
    logic [7:0] exp_word_b;  // same for dut_b

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Latch data must match the accepted word every cycle the enable is open.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && latch_enable === 1'b1)
            check_eq("a_stable_en", latch_data, exp_word);
        if (rst_n === 1'b1 && latch_enable_b === 1'b1)
            check_eq("b_stable_en", latch_data_b, exp_word_b);
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        exp_word   = 8'h00;
        exp_word_b = 8'h00;
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h77;
        in_valid_b = 1'b0;
        in_data_b  = 8'h00;

        // 1: reset held 3 cycles with in_valid high
        for (int k = 0; k < 3; k++) begin
            wait_cycle();
            check_eq("t1_en",    latch_enable, 1'b0);
            check_eq("t1_data",  latch_data,   8'h00);
            check_eq("t1_ready", in_ready,     1'b0);
            check_eq("t1_busy",  busy,         1'b0);
            check_eq("t1_done",  done,         1'b0);
        end
        check_eq("t1_b_ready", in_ready_b, 1'b0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        wait_cycle();
        check_eq("t1_post_ready", in_ready,   1'b1);
        check_eq("t1_post_data",  latch_data, 8'h00);
        check_eq("t1_post_busy",  busy,       1'b0);
        check_eq("t1_b_post_ready", in_ready_b, 1'b1);

        // 2: single write of A5
        in_data  = 8'hA5;
        in_valid = 1'b1;
        wait_cycle();
        for (int k = 0; k < 8; k++) begin
            exp_word = 8'hA5;
            check_eq("t2_data",  latch_data,   8'hA5);
            check_eq("t2_en",    latch_enable, (k >= 2 && k <= 4));
            check_eq("t2_done",  done,         (k == 6));
            check_eq("t2_busy",  busy,         (k <= 5));
            check_eq("t2_ready", in_ready,     (k >= 6));
            if (k == 0) in_valid = 1'b0;
            if (k < 7) wait_cycle();
        end

        // 3: back-to-back A5, 3C, FF with in_valid held high
        in_data  = 8'hA5;
        in_valid = 1'b1;
        wait_cycle();
        for (int k = 0; k < 22; k++) begin
            logic [7:0] exp_ld;
            logic       exp_rdy;
            exp_ld   = (k < 7) ? 8'hA5 : (k < 14) ? 8'h3C : 8'hFF;
            exp_rdy  = ((k % 7) == 6) || (k == 21);
            exp_word = exp_ld;
            check_eq("t3_data",  latch_data,   exp_ld);
            check_eq("t3_en",    latch_enable, ((k % 7) >= 2 && (k % 7) <= 4));
            check_eq("t3_done",  done,         ((k % 7) == 6));
            check_eq("t3_ready", in_ready,     exp_rdy);
            check_eq("t3_busy",  busy,         !exp_rdy);
            if (k == 6)  in_data  = 8'h3C;
            if (k == 13) in_data  = 8'hFF;
            if (k == 20) in_valid = 1'b0;
            if (k < 21) wait_cycle();
        end

        // 4: in_data changes to 00 during OPEN; held until in_ready returns
        in_data  = 8'hA5;
        in_valid = 1'b1;
        wait_cycle();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] exp_ld;
            exp_ld   = (k < 7) ? 8'hA5 : 8'h00;
            exp_word = exp_ld;
            check_eq("t4_data",  latch_data, exp_ld);
            check_eq("t4_ready", in_ready,   (k == 6));
            if (k == 2) in_data = 8'h00;
            if (k < 7) wait_cycle();
        end
        in_valid = 1'b0;
        exp_word = 8'h00;
        repeat (7) wait_cycle();
        check_eq("t4_end_ready", in_ready, 1'b1);
        check_eq("t4_end_done",  done,     1'b0);
        check_eq("t4_end_data",  latch_data, 8'h00);

        // 5: reset sampled at t0+3 while OPEN
        in_data  = 8'h5A;
        in_valid = 1'b1;
        wait_cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_word = 8'h5A;
            check_eq("t5_data", latch_data,   8'h5A);
            check_eq("t5_en",   latch_enable, (k == 2));
            if (k == 2) rst_n = 1'b0;
            wait_cycle();
        end
        check_eq("t5_rst_en",    latch_enable, 1'b0);
        check_eq("t5_rst_data",  latch_data,   8'h00);
        check_eq("t5_rst_state", dbg_state,    2'd0);
        check_eq("t5_rst_done",  done,         1'b0);
        check_eq("t5_rst_ready", in_ready,     1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_cycle();
            check_eq("t5_no_done", done,     1'b0);
            check_eq("t5_ready",   in_ready, 1'b1);
        end

        // 6: minimum timing on dut_b
        in_data_b  = 8'hC3;
        in_valid_b = 1'b1;
        wait_cycle();
        for (int k = 0; k < 5; k++) begin
            exp_word_b = 8'hC3;
            check_eq("t6_data",  latch_data_b,   8'hC3);
            check_eq("t6_en",    latch_enable_b, (k == 1));
            check_eq("t6_done",  done_b,         (k == 3));
            check_eq("t6_ready", in_ready_b,     (k >= 3));
            check_eq("t6_state", dbg_state_b,    (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : (k == 2) ? 2'd3 : 2'd0);
            if (k == 0) in_valid_b = 1'b0;
            if (k < 4) wait_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
